panda_mem_stage: RTL and testbench

MEM stage of the Panda pipeline: consumes the EX/MEM register (`ex_mem_t`) and performs data-memory loads and stores over a req/gnt/rvalid bus. It aligns store data and byte-enables, extracts and extends load data, selects the writeback value, and registers it into `mem_wb_t`. While a bus transaction is outstanding it raises `stall_o` to freeze the upstream pipeline and inserts bubbles toward WB.

---
 rtl/panda_pkg.sv | 47 ++++
 rtl/panda_lsu_align.sv | 46 ++++
 rtl/panda_mem_stage.sv | 137 +++++++++++++
 tb/tb_panda_mem_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared Panda pipeline types: stage registers, writeback select, LSU width and LSU FSM state.
package panda_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned BE_W   = XLEN / 8;

  typedef enum logic [1:0] {
    RD_DATA_ALU    = 2'd0,
    RD_DATA_MEM    = 2'd1,
    RD_DATA_PC_INC = 2'd2,
    RD_DATA_IMM    = 2'd3
  } rd_data_sel_e;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_width_e;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   rs2_data;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc_inc;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_we;
    rd_data_sel_e      rd_data_sel;
    logic              lsu_store;
    lsu_width_e        lsu_width;
    logic              lsu_load_unsigned;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0]   rd_data;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_we;
  } mem_wb_t;

endpackage

// File: rtl/panda_lsu_align.sv
// Combinational LSU lane logic: store byte-enables/replication, load extract/extend,
// and misalignment detection for the low address bits.
module panda_lsu_align
  import panda_pkg::*;
(
  input  lsu_width_e        width_i,
  input  logic [1:0]        offset_i,
  input  logic              load_unsigned_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic              misaligned_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted      = rdata_i >> {offset_i, 3'b000};
    be_o         = 4'b1111;
    wdata_o      = store_data_i;
    load_data_o  = rdata_i;
    misaligned_o = (offset_i != 2'b00);
    unique case (width_i)
      LSU_BYTE: begin
        be_o         = 4'b0001 << offset_i;
        wdata_o      = {4{store_data_i[7:0]}};
        misaligned_o = 1'b0;
        load_data_o  = load_unsigned_i ? {24'd0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      end
      LSU_HALF: begin
        be_o         = 4'b0011 << offset_i;
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = offset_i[0];
        load_data_o  = load_unsigned_i ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        // Word accesses (and the unused encoding) keep the defaults.
      end
    endcase
  end

endmodule

// File: rtl/panda_mem_stage.sv
// Panda MEM stage: issues loads/stores on a req/gnt/rvalid bus, stalls upstream while a
// transaction is outstanding, and registers the selected writeback value into MEM/WB.
module panda_mem_stage
  import panda_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  ex_mem_t             ex_mem_i,
  input  logic [REG_AW-1:0]   wb_rd_addr_i,
  input  logic                wb_rd_we_i,
  input  logic [XLEN-1:0]     wb_rd_data_i,
  output logic                data_req_o,
  output logic [XLEN-1:0]     data_addr_o,
  output logic                data_we_o,
  output logic [BE_W-1:0]     data_be_o,
  output logic [XLEN-1:0]     data_wdata_o,
  input  logic                data_gnt_i,
  input  logic                data_rvalid_i,
  input  logic [XLEN-1:0]     data_rdata_i,
  output logic                stall_o,
  output logic                misaligned_o,
  output mem_wb_t             mem_wb_o
);

  lsu_state_e        state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              we_q, we_d;
  mem_wb_t           mem_wb_q, mem_wb_d;

  logic              is_load, is_store, is_access, fwd_hit;
  logic              al_mis, aligned_access;
  logic [XLEN-1:0]   store_data, issue_addr, al_wdata, load_data, wb_data;
  logic [BE_W-1:0]   al_be;

  assign is_load    = (ex_mem_i.rd_data_sel == RD_DATA_MEM);
  assign is_store   = ex_mem_i.lsu_store;
  assign is_access  = is_load || is_store;
  // WB bypass for store data; only meaningful in the issue cycle since wdata is held afterwards.
  assign fwd_hit    = wb_rd_we_i && (wb_rd_addr_i == ex_mem_i.rs2_addr) &&
                      (ex_mem_i.rs2_addr != '0);
  assign store_data = fwd_hit ? wb_rd_data_i : ex_mem_i.rs2_data;
  assign issue_addr = {ex_mem_i.alu_result[XLEN-1:2], 2'b00};

  panda_lsu_align u_align (
    .width_i         (ex_mem_i.lsu_width),
    .offset_i        (ex_mem_i.alu_result[1:0]),
    .load_unsigned_i (ex_mem_i.lsu_load_unsigned),
    .store_data_i    (store_data),
    .rdata_i         (data_rdata_i),
    .be_o            (al_be),
    .wdata_o         (al_wdata),
    .load_data_o     (load_data),
    .misaligned_o    (al_mis)
  );

  assign aligned_access = is_access && !al_mis;
  assign misaligned_o   = is_access && al_mis;
  assign stall_o        = aligned_access && !((state_q == WAIT_RVALID) && data_rvalid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      mem_wb_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Bus FSM: issue straight from EX/MEM in IDLE, replay held request while waiting for gnt.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    data_req_o   = 1'b0;
    data_addr_o  = addr_q;
    data_we_o    = we_q;
    data_be_o    = be_q;
    data_wdata_o = wdata_q;
    unique case (state_q)
      IDLE: begin
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        if (aligned_access) begin
          data_req_o   = 1'b1;
          data_addr_o  = issue_addr;
          data_we_o    = is_store;
          data_be_o    = al_be;
          data_wdata_o = al_wdata;
          addr_d       = issue_addr;
          we_d         = is_store;
          be_d         = al_be;
          wdata_d      = al_wdata;
          state_d      = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_data = ex_mem_i.imm;
    unique case (ex_mem_i.rd_data_sel)
      RD_DATA_ALU:    wb_data = ex_mem_i.alu_result;
      RD_DATA_MEM:    wb_data = load_data;
      RD_DATA_PC_INC: wb_data = ex_mem_i.pc_inc;
      default:        wb_data = ex_mem_i.imm;
    endcase
    mem_wb_d.rd_data = wb_data;
    mem_wb_d.rd_addr = ex_mem_i.rd_addr;
    mem_wb_d.rd_we   = ex_mem_i.rd_we && !misaligned_o && !stall_o;
  end

  assign mem_wb_o = mem_wb_q;

endmodule

// File: tb/tb_panda_mem_stage.sv
// Bench for panda_mem_stage: transaction-level reference model driving random and directed
// instructions with variable gnt/rvalid latency; one per-cycle compare process.
module tb_panda_mem_stage;
  import panda_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  ex_mem_t     ex_mem;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_we;
  logic [31:0] wb_rd_data;
  logic        data_req, data_we, data_gnt, data_rvalid, stall, misaligned;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;
  mem_wb_t     mem_wb;

  always #5 clk = ~clk;

  panda_mem_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ex_mem_i      (ex_mem),
    .wb_rd_addr_i  (wb_rd_addr),
    .wb_rd_we_i    (wb_rd_we),
    .wb_rd_data_i  (wb_rd_data),
    .data_req_o    (data_req),
    .data_addr_o   (data_addr),
    .data_we_o     (data_we),
    .data_be_o     (data_be),
    .data_wdata_o  (data_wdata),
    .data_gnt_i    (data_gnt),
    .data_rvalid_i (data_rvalid),
    .data_rdata_i  (data_rdata),
    .stall_o       (stall),
    .misaligned_o  (misaligned),
    .mem_wb_o      (mem_wb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        chk_en = 1'b0;
  logic        exp_req, exp_stall, exp_mis, exp_we;
  logic        chk_addr, chk_store_bus, chk_zero;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  mem_wb_t     exp_wb, nxt_wb;
  logic        exp_wb_full, nxt_wb_full;

  logic        obs_req, obs_mis;
  int          obs_stall_cnt;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req", 32'(data_req), 32'(exp_req));
      check("stall", 32'(stall), 32'(exp_stall));
      check("misaligned", 32'(misaligned), 32'(exp_mis));
      if (chk_addr) begin
        check("addr", data_addr, exp_addr);
        check("we", 32'(data_we), 32'(exp_we));
      end
      if (chk_store_bus) begin
        check("be", 32'(data_be), 32'(exp_be));
        check("wdata", data_wdata, exp_wdata);
      end
      if (chk_zero) begin
        check("idle_addr", data_addr, 32'h0);
        check("idle_we", 32'(data_we), 32'h0);
        check("idle_be", 32'(data_be), 32'h0);
        check("idle_wdata", data_wdata, 32'h0);
      end
      check("wb_we", 32'(mem_wb.rd_we), 32'(exp_wb.rd_we));
      if (exp_wb_full) begin
        check("wb_data", mem_wb.rd_data, exp_wb.rd_data);
        check("wb_addr", 32'(mem_wb.rd_addr), 32'(exp_wb.rd_addr));
      end
    end
  end

  function automatic logic [31:0] model_load(logic [31:0] rd, logic [1:0] off,
                                             lsu_width_e w, logic uns);
    logic [31:0] sh, v;
    sh = rd >> (8 * int'(off));
    if (w == LSU_BYTE) begin
      v = sh % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (w == LSU_HALF) begin
      v = sh % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic model_mis(lsu_width_e w, logic [1:0] off);
    return (w == LSU_HALF && (off % 2) != 0) || (w == LSU_WORD && off != 0);
  endfunction

  function automatic logic [31:0] model_wb(ex_mem_t i, logic [31:0] ld);
    case (i.rd_data_sel)
      RD_DATA_ALU:    return i.alu_result;
      RD_DATA_MEM:    return ld;
      RD_DATA_PC_INC: return i.pc_inc;
      default:        return i.imm;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    exp_wb      = nxt_wb;
    exp_wb_full = nxt_wb_full;
  endtask

  // Present one instruction and play the bus for it: gd cycles before gnt, rdl before rvalid.
  task automatic run_instr(input ex_mem_t ins, input int gd, input int rdl,
                           input logic [4:0] fa, input logic fwe, input logic [31:0] fd,
                           input logic [31:0] rdata);
    logic        ld, st, acc, mis;
    logic [1:0]  off;
    logic [31:0] sd, wbv;
    int          total;
    off = ins.alu_result[1:0];
    ld  = (ins.rd_data_sel == RD_DATA_MEM);
    st  = ins.lsu_store;
    acc = ld || st;
    mis = acc && model_mis(ins.lsu_width, off);
    sd  = (fwe && fa == ins.rs2_addr && ins.rs2_addr != 0) ? fd : ins.rs2_data;
    obs_req = 1'b0; obs_mis = 1'b0; obs_stall_cnt = 0;
    obs_addr = '0; obs_be = '0; obs_wdata = '0;

    exp_addr  = ins.alu_result & 32'hFFFFFFFC;
    exp_we    = st;
    exp_be    = (ins.lsu_width == LSU_BYTE) ? 4'(1 << off) :
                (ins.lsu_width == LSU_HALF) ? 4'(3 << off) : 4'hF;
    exp_wdata = (ins.lsu_width == LSU_BYTE) ? 32'(sd[7:0]) * 32'h01010101 :
                (ins.lsu_width == LSU_HALF) ? 32'(sd[15:0]) * 32'h00010001 : sd;

    total = (!acc || mis) ? 1 : gd + rdl + 2;
    for (int c = 0; c < total; c++) begin
      step();
      ex_mem = ins;
      if (c == 0) begin
        wb_rd_addr = fa; wb_rd_we = fwe; wb_rd_data = fd;
      end else begin
        wb_rd_addr = 5'($urandom); wb_rd_we = 1'($urandom); wb_rd_data = $urandom;
      end
      if (!acc || mis) begin
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = $urandom;
        exp_req = 1'b0; exp_stall = 1'b0; exp_mis = mis;
        chk_addr = 1'b0; chk_store_bus = 1'b0; chk_zero = (ins == '0);
        nxt_wb.rd_data = model_wb(ins, 32'h0);
        nxt_wb.rd_addr = ins.rd_addr;
        nxt_wb.rd_we   = ins.rd_we && !mis;
        nxt_wb_full    = !mis;
      end else begin
        data_gnt    = (c == gd);
        data_rvalid = (c == total - 1);
        data_rdata  = data_rvalid ? rdata : $urandom;
        exp_req     = (c <= gd);
        exp_stall   = (c != total - 1);
        exp_mis     = 1'b0;
        chk_addr    = exp_req;
        chk_store_bus = exp_req && st;
        chk_zero    = 1'b0;
        if (c == total - 1) begin
          wbv = model_wb(ins, model_load(rdata, off, ins.lsu_width, ins.lsu_load_unsigned));
          nxt_wb.rd_data = wbv;
          nxt_wb.rd_addr = ins.rd_addr;
          nxt_wb.rd_we   = ins.rd_we;
          nxt_wb_full    = 1'b1;
        end else begin
          nxt_wb.rd_we = 1'b0;
          nxt_wb_full  = 1'b0;
        end
      end
      @(negedge clk);
      obs_req = obs_req | data_req;
      obs_mis = obs_mis | misaligned;
      obs_stall_cnt += int'(stall);
      if (data_req) begin
        obs_addr = data_addr; obs_be = data_be; obs_wdata = data_wdata;
      end
    end
  endtask

  task automatic bubble();
    run_instr('0, 0, 0, 5'd0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic ex_mem_t rand_instr();
    ex_mem_t i;
    int k;
    i.alu_result = $urandom;
    i.rs2_data   = $urandom;
    i.rs2_addr   = 5'($urandom);
    i.imm        = $urandom;
    i.pc_inc     = $urandom;
    i.rd_addr    = 5'($urandom);
    i.rd_we      = 1'($urandom);
    i.lsu_store  = 1'b0;
    i.rd_data_sel = rd_data_sel_e'(2'($urandom_range(0, 3)));
    i.lsu_width  = lsu_width_e'(2'($urandom_range(0, 2)));
    i.lsu_load_unsigned = 1'($urandom);
    k = $urandom_range(0, 9);
    if (k < 3) begin
      i.lsu_store = 1'b1;
      i.rd_data_sel = RD_DATA_ALU;
    end else if (k < 6) begin
      i.rd_data_sel = RD_DATA_MEM;
    end else if (i.rd_data_sel == RD_DATA_MEM) begin
      i.rd_data_sel = RD_DATA_PC_INC;
    end
    if ($urandom_range(0, 1) == 1) begin
      if (i.lsu_width == LSU_WORD) i.alu_result[1:0] = 2'b00;
      else if (i.lsu_width == LSU_HALF) i.alu_result[0] = 1'b0;
    end
    return i;
  endfunction

  ex_mem_t ins;

  initial begin
    rst = 1'b1; ex_mem = '0; wb_rd_addr = '0; wb_rd_we = 1'b0; wb_rd_data = '0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0; exp_we = 1'b0;
    chk_addr = 1'b0; chk_store_bus = 1'b0; chk_zero = 1'b1;
    exp_addr = '0; exp_wdata = '0; exp_be = '0;
    nxt_wb = '0; nxt_wb_full = 1'b1; exp_wb = '0; exp_wb_full = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_wb_we", 32'(mem_wb.rd_we), 32'h0);
    check("reset_wb_data", mem_wb.rd_data, 32'h0);
    step();
    rst = 1'b0;

    // ALU pass-through
    ins = '0;
    ins.alu_result = 32'h1234; ins.rd_addr = 5'd5; ins.rd_we = 1'b1;
    run_instr(ins, 0, 0, 5'd0, 1'b0, 32'h0, 32'h0);
    check("alu_no_req", 32'(obs_req), 32'h0);
    bubble();
    check("alu_wb_data", mem_wb.rd_data, 32'h1234);
    check("alu_wb_addr", 32'(mem_wb.rd_addr), 32'd5);
    check("alu_wb_we", 32'(mem_wb.rd_we), 32'h1);

    // LB / LBU from 0x1003, zero-wait
    ins = '0;
    ins.alu_result = 32'h1003; ins.rd_data_sel = RD_DATA_MEM; ins.lsu_width = LSU_BYTE;
    ins.rd_addr = 5'd3; ins.rd_we = 1'b1;
    run_instr(ins, 0, 0, 5'd0, 1'b0, 32'h0, 32'h80A5A5A5);
    check("lb_addr", obs_addr, 32'h1000);
    check("lb_stall_cycles", 32'(obs_stall_cnt), 32'd1);
    bubble();
    check("lb_data", mem_wb.rd_data, 32'hFFFFFF80);
    ins.lsu_load_unsigned = 1'b1;
    run_instr(ins, 0, 0, 5'd0, 1'b0, 32'h0, 32'h80A5A5A5);
    bubble();
    check("lbu_data", mem_wb.rd_data, 32'h00000080);

    // SH to 0x2002 with 3-cycle gnt delay
    ins = '0;
    ins.alu_result = 32'h2002; ins.lsu_store = 1'b1; ins.lsu_width = LSU_HALF;
    ins.rs2_data = 32'h1234ABCD; ins.rs2_addr = 5'd9;
    run_instr(ins, 3, 0, 5'd0, 1'b0, 32'h0, 32'h0);
    check("sh_addr", obs_addr, 32'h2000);
    check("sh_be", 32'(obs_be), 32'hC);
    check("sh_wdata", obs_wdata, 32'hABCDABCD);
    check("sh_stall_cycles", 32'(obs_stall_cnt), 32'd4);

    // SW with forwarding from WB in the issue cycle, gnt delayed so WB changes meanwhile
    ins = '0;
    ins.alu_result = 32'h3000; ins.lsu_store = 1'b1; ins.lsu_width = LSU_WORD;
    ins.rs2_data = 32'h11111111; ins.rs2_addr = 5'd7;
    run_instr(ins, 2, 1, 5'd7, 1'b1, 32'hDEADBEEF, 32'h0);
    check("sw_fwd_wdata", obs_wdata, 32'hDEADBEEF);

    // LW misaligned
    ins = '0;
    ins.alu_result = 32'h1002; ins.rd_data_sel = RD_DATA_MEM; ins.lsu_width = LSU_WORD;
    ins.rd_addr = 5'd4; ins.rd_we = 1'b1;
    run_instr(ins, 0, 0, 5'd0, 1'b0, 32'h0, 32'h0);
    check("lw_mis_pulse", 32'(obs_mis), 32'h1);
    check("lw_mis_no_req", 32'(obs_req), 32'h0);
    bubble();
    check("lw_mis_wb_we", 32'(mem_wb.rd_we), 32'h0);

    // Reset while waiting for rvalid; the late rvalid must be ignored
    ins = '0;
    ins.alu_result = 32'h3000; ins.rd_data_sel = RD_DATA_MEM; ins.lsu_width = LSU_WORD;
    ins.rd_addr = 5'd6; ins.rd_we = 1'b1;
    step();
    ex_mem = ins; data_gnt = 1'b1; data_rvalid = 1'b0;
    exp_req = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0; chk_addr = 1'b1; exp_addr = 32'h3000;
    exp_we = 1'b0; chk_store_bus = 1'b0; chk_zero = 1'b0;
    nxt_wb.rd_we = 1'b0; nxt_wb_full = 1'b0;
    step();
    rst = 1'b1; ex_mem = '0; data_gnt = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0; chk_addr = 1'b0;
    nxt_wb = '0; nxt_wb_full = 1'b1;
    step();
    rst = 1'b0; data_rvalid = 1'b1; data_rdata = 32'hCAFEF00D; chk_zero = 1'b1;
    @(negedge clk);
    check("rst_late_req", 32'(data_req), 32'h0);
    check("rst_late_stall", 32'(stall), 32'h0);
    step();
    data_rvalid = 1'b0;
    check("rst_wb_we", 32'(mem_wb.rd_we), 32'h0);
    check("rst_wb_data", mem_wb.rd_data, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] fa;
      ins = rand_instr();
      fa = ($urandom_range(0, 1) == 1) ? ins.rs2_addr : 5'($urandom);
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                fa, 1'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 4) == 0) bubble();
    end
    bubble();
    bubble();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
